// File: rtl/pps_gen.sv
// pps_gen: programmable pulse-per-second generator with optional phase alignment
// to a receiver flag, seconds counter and captured alignment phase.
module pps_gen #(
   parameter int unsigned PERIOD_BITS    = 32,
   parameter int unsigned DEFAULT_PERIOD = 1000000,
   parameter int unsigned DEFAULT_WIDTH  = 100000
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   enable_i,
   input  logic [PERIOD_BITS-1:0] period_i,
   input  logic                   period_wr_i,
   input  logic [PERIOD_BITS-1:0] width_i,
   input  logic                   width_wr_i,
   input  logic                   align_en_i,
   input  logic                   align_i,
   output logic                   pps_o,
   output logic                   pps_flag_o,
   output logic [31:0]            sec_count_o,
   output logic [PERIOD_BITS-1:0] align_phase_o,
   output logic                   align_valid_o
);
   localparam int unsigned W = PERIOD_BITS;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [W-1:0] cnt, cnt_n, act_period, ap_n, act_width, aw_n, pend_period, pp_n, pend_width, pw_n;
   logic [W-1:0] phase_n, pmax, clamp_w, eff_w, cnt_inc;
   logic [31:0]  sec_n;
   logic         pps_n, flag_n, av_n, align_hit, wrap;
   assign pmax      = act_period - W'(1);
   assign clamp_w   = act_width > pmax ? pmax : act_width;
   // at least one high and one low cycle whatever the programmed width
   assign eff_w     = clamp_w == '0 ? W'(1) : clamp_w;
   assign cnt_inc   = cnt + W'(1);
   assign align_hit = align_en_i & align_i;
   assign wrap      = cnt == pmax;
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ap_n    = act_period;
      aw_n    = act_width;
      pp_n    = (period_wr_i && period_i > W'(1)) ? period_i : pend_period;
      pw_n    = width_wr_i ? width_i : pend_width;
      pps_n   = 1'b0;
      flag_n  = 1'b0;
      sec_n   = sec_count_o;
      phase_n = align_phase_o;
      av_n    = 1'b0;
      if (state == IDLE) begin
         ap_n  = pend_period;
         aw_n  = pend_width;
         cnt_n = '0;
         if (enable_i) begin
            state_n = RUN;
            pps_n   = 1'b1;
            flag_n  = 1'b1;
            sec_n   = '0;
         end
      end else if (!enable_i) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else if (wrap || align_hit) begin
         // registered pending values load here, so a write in this cycle waits a period
         cnt_n   = '0;
         pps_n   = 1'b1;
         flag_n  = 1'b1;
         sec_n   = sec_count_o + 32'd1;
         ap_n    = pend_period;
         aw_n    = pend_width;
         phase_n = align_hit ? cnt : align_phase_o;
         av_n    = align_hit;
      end else begin
         cnt_n = cnt_inc;
         pps_n = cnt_inc < eff_w;
      end
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= IDLE;
         cnt           <= '0;
         act_period    <= W'(DEFAULT_PERIOD);
         pend_period   <= W'(DEFAULT_PERIOD);
         act_width     <= W'(DEFAULT_WIDTH);
         pend_width    <= W'(DEFAULT_WIDTH);
         pps_o         <= 1'b0;
         pps_flag_o    <= 1'b0;
         sec_count_o   <= '0;
         align_phase_o <= '0;
         align_valid_o <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         act_period    <= ap_n;
         pend_period   <= pp_n;
         act_width     <= aw_n;
         pend_width    <= pw_n;
         pps_o         <= pps_n;
         pps_flag_o    <= flag_n;
         sec_count_o   <= sec_n;
         align_phase_o <= phase_n;
         align_valid_o <= av_n;
      end
   end
endmodule

// File: tb/tb_pps_gen.sv
// tb_pps_gen: scoreboard bench for pps_gen with a cycle-level reference model of
// the period/width/align rules, directed scenarios and randomized traffic.
module tb_pps_gen;
   logic        clk, rst_n, enable, period_wr, width_wr, align_en, align;
   logic [31:0] period_v, width_v;
   logic        pps, flag, av;
   logic [31:0] sec, phase;

   pps_gen #(.PERIOD_BITS(32), .DEFAULT_PERIOD(10), .DEFAULT_WIDTH(3)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable),
      .period_i(period_v), .period_wr_i(period_wr),
      .width_i(width_v), .width_wr_i(width_wr),
      .align_en_i(align_en), .align_i(align),
      .pps_o(pps), .pps_flag_o(flag), .sec_count_o(sec),
      .align_phase_o(phase), .align_valid_o(av)
   );

   typedef struct {bit pps; bit flag; bit [31:0] sec; bit [31:0] phase; bit av;} exp_t;
   exp_t q[$];
   int checks = 0, failures = 0, cycle = 0;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // reference model state: running flag, position in period, active/pending settings
   bit          m_run;
   int unsigned m_cnt, m_per, m_wid, m_pper, m_pwid;
   bit [31:0]   m_sec, m_phase;
   bit          m_pps, m_flag, m_av;

   function automatic int unsigned high_time(int unsigned p, int unsigned w);
      int unsigned h = (w < p - 1) ? w : p - 1;
      return (h < 1) ? 1 : h;
   endfunction

   always @(posedge clk) begin
      int unsigned op, ow;
      bit restart, hit;
      cycle++;
      if (!rst_n) begin
         m_run = 0; m_cnt = 0; m_per = 10; m_wid = 3; m_pper = 10; m_pwid = 3;
         m_sec = 0; m_phase = 0; m_pps = 0; m_flag = 0; m_av = 0;
      end else begin
         op = m_pper; ow = m_pwid;
         if (period_wr && period_v >= 2) m_pper = period_v;
         if (width_wr) m_pwid = width_v;
         m_flag = 0; m_av = 0;
         if (!m_run) begin
            m_per = op; m_wid = ow; m_cnt = 0; m_pps = 0;
            if (enable) begin m_run = 1; m_sec = 0; m_pps = 1; m_flag = 1; end
         end else if (!enable) begin
            m_run = 0; m_cnt = 0; m_pps = 0;
         end else begin
            hit = align_en && align;
            restart = hit || (m_cnt == m_per - 1);
            if (hit) begin m_phase = m_cnt; m_av = 1; end
            if (restart) begin
               m_cnt = 0; m_per = op; m_wid = ow; m_sec++; m_pps = 1; m_flag = 1;
            end else begin
               m_cnt++;
               m_pps = m_cnt < high_time(m_per, m_wid);
            end
         end
      end
      q.push_back('{m_pps, m_flag, m_sec, m_phase, m_av});
   end

   always @(posedge clk) begin
      exp_t e;
      #1;
      checks++;
      if (q.size() == 0) begin
         failures++;
         $display("FAIL cycle %0d scoreboard empty", cycle);
      end else begin
         e = q.pop_front();
         if (pps !== e.pps || flag !== e.flag || sec !== e.sec || phase !== e.phase || av !== e.av) begin
            failures++;
            $display("FAIL cycle %0d outputs got pps=%b flag=%b sec=%0d phase=%0d av=%b expected pps=%b flag=%b sec=%0d phase=%0d av=%b",
                     cycle, pps, flag, sec, phase, av, e.pps, e.flag, e.sec, e.phase, e.av);
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cnt(int unsigned v);
      int b = 0;
      @(negedge clk);
      while (!(m_run && m_cnt == v)) begin
         @(negedge clk);
         if (++b > 60) begin
            checks++; failures++;
            $display("FAIL wait_cnt timeout waiting for counter=%0d got %0d", v, m_cnt);
            return;
         end
      end
   endtask

   task automatic wr_period(int unsigned v);
      period_v = v; period_wr = 1; @(negedge clk); period_wr = 0;
   endtask

   task automatic wr_width(int unsigned v);
      width_v = v; width_wr = 1; @(negedge clk); width_wr = 0;
   endtask

   task automatic pulse_align;
      align = 1; @(negedge clk); align = 0;
   endtask

   initial begin
      rst_n = 0; enable = 0; period_wr = 0; width_wr = 0; align_en = 0; align = 0;
      period_v = 0; width_v = 0;
      cyc(3);
      rst_n = 1;
      cyc(3);
      enable = 1;
      cyc(35);
      wait_cnt(4);
      wr_period(6);
      wr_width(20);
      wr_period(1);
      cyc(30);
      wr_period(10);
      wr_width(3);
      cyc(14);
      wait_cnt(9);
      wr_period(8);
      cyc(25);
      align_en = 1;
      wait_cnt(7);
      pulse_align();
      cyc(3);
      wait_cnt(m_per - 1);
      pulse_align();
      cyc(2);
      wait_cnt(0);
      pulse_align();
      cyc(3);
      align_en = 0;
      wait_cnt(3);
      pulse_align();
      cyc(12);
      wait_cnt(1);
      enable = 0;
      cyc(3);
      enable = 1;
      cyc(15);
      repeat (500) begin
         @(negedge clk);
         period_wr = ($urandom % 8) == 0;
         period_v  = $urandom_range(0, 12);
         width_wr  = ($urandom % 8) == 0;
         width_v   = $urandom_range(0, 14);
         align_en  = $urandom % 2;
         align     = ($urandom % 7) == 0;
         enable    = ($urandom % 40) != 0;
      end
      period_wr = 0; width_wr = 0; align = 0; align_en = 0; enable = 1;
      cyc(20);
      @(posedge clk);
      #3 rst_n = 0;
      #1;
      checks++;
      if (pps !== 0 || flag !== 0 || sec !== 0 || phase !== 0 || av !== 0) begin
         failures++;
         $display("FAIL async_reset got pps=%b flag=%b sec=%0d phase=%0d av=%b expected all zero", pps, flag, sec, phase, av);
      end
      cyc(3);
      rst_n = 1;
      cyc(25);
      enable = 0;
      cyc(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
